// File: rtl/stream_prefetcher_if.sv
// Handshake/bus bundle of the stream prefetcher: the cache miss-path side
// (trigger, flush, lookup) and the memory arbiter side (read request/response).
// The slave modport is the prefetcher's view; master is the surrounding system.
interface stream_prefetcher_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BITS  = 256
);
    logic                  trigger;
    logic [ADDR_WIDTH-1:0] trigger_addr;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] lookup_addr;
    logic                  lookup_consume;
    logic                  lookup_hit;
    logic [LINE_BITS-1:0]  lookup_data;
    logic                  busy;
    logic                  mem_read;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [LINE_BITS-1:0]  mem_rdata;
    logic                  mem_resp;

    modport master (
        output trigger, trigger_addr, flush, lookup_addr, lookup_consume,
        output mem_rdata, mem_resp,
        input  lookup_hit, lookup_data, busy, mem_read, mem_address
    );

    modport slave (
        input  trigger, trigger_addr, flush, lookup_addr, lookup_consume,
        input  mem_rdata, mem_resp,
        output lookup_hit, lookup_data, busy, mem_read, mem_address
    );
endinterface

// File: rtl/stream_prefetcher.sv
// Sequential N-line stream prefetcher. A trigger starts fetching the DEPTH
// lines following the demand-miss line (one read outstanding at a time,
// never crossing a page) into a small fully-associative buffer that the
// cache probes combinationally and may consume from.
module stream_prefetcher #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BITS  = 256,
    parameter int DEPTH      = 4,
    parameter int PAGE_BITS  = 12
) (
    input  logic               clk,
    input  logic               rst,
    stream_prefetcher_if.slave bus
);
    localparam int LB = LINE_BITS / 8;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LB - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_INC  = ADDR_WIDTH'(LB);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ABORT
    } state_t;

    state_t                r_state, w_state_nx;
    logic [ADDR_WIDTH-1:0] r_next_addr, w_next_addr_nx;
    logic [CW-1:0]         r_remaining, w_remaining_nx;
    logic [PW-1:0]         r_wr_ptr, w_wr_ptr_nx;
    logic                  r_pend_valid, w_pend_valid_nx;
    logic [ADDR_WIDTH-1:0] r_pend_addr, w_pend_addr_nx;

    logic [DEPTH-1:0]      r_valid;
    logic [ADDR_WIDTH-1:0] r_tag  [DEPTH];
    logic [LINE_BITS-1:0]  r_data [DEPTH];

    logic                  w_inv_all;
    logic                  w_write;
    logic                  w_start;
    logic [ADDR_WIDTH-1:0] w_start_src;
    logic [ADDR_WIDTH-1:0] w_start_next;
    logic                  w_start_cross;
    logic [ADDR_WIDTH-1:0] w_fetch_inc;
    logic                  w_fetch_cross;
    logic [ADDR_WIDTH-1:0] w_lookup_line;
    logic                  w_hit;
    logic [PW-1:0]         w_hit_idx;
    logic [LINE_BITS-1:0]  w_hit_data;

    // Stream start address and page-crossing tests for start and advance
    always_comb begin
        w_start_src   = (r_state == ABORT && !bus.trigger) ? r_pend_addr : bus.trigger_addr;
        w_start_next  = (w_start_src & LINE_MASK) + LINE_INC;
        w_start_cross = (w_start_next[ADDR_WIDTH-1:PAGE_BITS] != w_start_src[ADDR_WIDTH-1:PAGE_BITS]);
        w_fetch_inc   = r_next_addr + LINE_INC;
        w_fetch_cross = (w_fetch_inc[ADDR_WIDTH-1:PAGE_BITS] != r_next_addr[ADDR_WIDTH-1:PAGE_BITS]);
    end

    // Next-state and control decode; flush beats trigger, a (re)start is applied last
    always_comb begin
        w_state_nx      = r_state;
        w_next_addr_nx  = r_next_addr;
        w_remaining_nx  = r_remaining;
        w_wr_ptr_nx     = r_wr_ptr;
        w_pend_valid_nx = r_pend_valid;
        w_pend_addr_nx  = r_pend_addr;
        w_inv_all       = 1'b0;
        w_write         = 1'b0;
        w_start         = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (bus.flush) begin
                    w_inv_all = 1'b1;
                end else if (bus.trigger) begin
                    w_start = 1'b1;
                end
            end
            FETCH: begin
                if (bus.flush) begin
                    w_inv_all       = 1'b1;
                    w_pend_valid_nx = 1'b0;
                    w_state_nx      = bus.mem_resp ? IDLE : ABORT;
                end else if (bus.mem_resp) begin
                    // A same-cycle trigger invalidates everything, so the response
                    // would be written only to be cleared; restarting directly is equivalent.
                    if (bus.trigger) begin
                        w_start = 1'b1;
                    end else begin
                        w_write        = 1'b1;
                        w_wr_ptr_nx    = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
                        w_remaining_nx = r_remaining - CW'(1);
                        w_next_addr_nx = w_fetch_inc;
                        if (w_remaining_nx == '0 || w_fetch_cross) begin
                            w_state_nx = IDLE;
                        end
                    end
                end else if (bus.trigger) begin
                    w_pend_valid_nx = 1'b1;
                    w_pend_addr_nx  = bus.trigger_addr;
                    w_state_nx      = ABORT;
                end
            end
            ABORT: begin
                if (bus.flush) begin
                    w_inv_all       = 1'b1;
                    w_pend_valid_nx = 1'b0;
                    if (bus.mem_resp) begin
                        w_state_nx = IDLE;
                    end
                end else begin
                    if (bus.trigger) begin
                        w_pend_valid_nx = 1'b1;
                        w_pend_addr_nx  = bus.trigger_addr;
                    end
                    if (bus.mem_resp) begin
                        if (bus.trigger || r_pend_valid) begin
                            w_start = 1'b1;
                        end else begin
                            w_state_nx = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase

        if (w_start) begin
            w_inv_all       = 1'b1;
            w_next_addr_nx  = w_start_next;
            w_remaining_nx  = CW'(DEPTH);
            w_wr_ptr_nx     = '0;
            w_pend_valid_nx = 1'b0;
            w_state_nx      = w_start_cross ? IDLE : FETCH;
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_next_addr  <= '0;
            r_remaining  <= '0;
            r_wr_ptr     <= '0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_next_addr  <= w_next_addr_nx;
            r_remaining  <= w_remaining_nx;
            r_wr_ptr     <= w_wr_ptr_nx;
            r_pend_valid <= w_pend_valid_nx;
            r_pend_addr  <= w_pend_addr_nx;
        end
    end

    assign w_lookup_line = bus.lookup_addr & LINE_MASK;

    // Fully-associative probe of the line buffer against pre-edge contents
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_hit_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && r_tag[i] == w_lookup_line) begin
                w_hit      = 1'b1;
                w_hit_idx  = PW'(i);
                w_hit_data = r_data[i];
            end
        end
    end

    // Line buffer: invalidate-all dominates; a fill at the same index overrides a consume
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (w_inv_all) begin
            r_valid <= '0;
        end else begin
            if (bus.lookup_consume && w_hit) begin
                r_valid[w_hit_idx] <= 1'b0;
            end
            if (w_write) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_tag[r_wr_ptr]   <= r_next_addr;
                r_data[r_wr_ptr]  <= bus.mem_rdata;
            end
        end
    end

    assign bus.lookup_hit  = w_hit;
    assign bus.lookup_data = w_hit_data;
    assign bus.busy        = (r_state != IDLE);
    assign bus.mem_read    = (r_state != IDLE);
    assign bus.mem_address = r_next_addr;
endmodule

// File: tb/tb_stream_prefetcher.sv
// Self-checking bench for stream_prefetcher: a directed stimulus sequence
// with literal expectations, plus an abstract model (a queue of lines still
// to be requested and an address-keyed buffer) compared every cycle.
module tb_stream_prefetcher;
    localparam int AW        = 32;
    localparam int LBITS     = 256;
    localparam int DEPTH     = 4;
    localparam int PAGE_BITS = 12;
    localparam int LB        = LBITS / 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    stream_prefetcher_if #(.ADDR_WIDTH(AW), .LINE_BITS(LBITS)) bus ();

    stream_prefetcher #(
        .ADDR_WIDTH(AW),
        .LINE_BITS (LBITS),
        .DEPTH     (DEPTH),
        .PAGE_BITS (PAGE_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [AW-1:0] req_log[$];

    // model state
    logic [LBITS-1:0] m_buf [logic [AW-1:0]];
    logic [AW-1:0]    m_reqs[$];
    bit               m_abort = 1'b0;
    bit               m_pend  = 1'b0;
    logic [AW-1:0]    m_cur   = '0;
    logic [AW-1:0]    m_pend_addr = '0;

    function automatic logic [AW-1:0] line(input logic [AW-1:0] a);
        return a & ~AW'(LB - 1);
    endfunction

    function automatic logic [LBITS-1:0] dat(input logic [AW-1:0] a);
        return {4{a ^ 32'hC3C3_0000, ~a}};
    endfunction

    task automatic chk(input string name, input logic [LBITS-1:0] act, input logic [LBITS-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic m_start(input logic [AW-1:0] a);
        logic [AW-1:0] nxt;
        m_buf.delete();
        m_reqs.delete();
        nxt = line(a);
        for (int k = 0; k < DEPTH; k++) begin
            nxt = nxt + AW'(LB);
            if (nxt[AW-1:PAGE_BITS] != a[AW-1:PAGE_BITS]) break;
            m_reqs.push_back(nxt);
        end
    endtask

    task automatic m_step();
        logic [AW-1:0] lk;
        logic [AW-1:0] wa;
        bit active;
        lk = line(bus.lookup_addr);
        if (bus.lookup_consume && m_buf.exists(lk)) m_buf.delete(lk);
        active = m_abort || (m_reqs.size() != 0);
        if (!active) begin
            if (bus.flush) m_buf.delete();
            else if (bus.trigger) m_start(bus.trigger_addr);
        end else if (!m_abort) begin
            if (bus.flush) begin
                m_buf.delete();
                m_pend = 1'b0;
                if (!bus.mem_resp) begin
                    m_abort = 1'b1;
                    m_cur   = m_reqs[0];
                end
                m_reqs.delete();
            end else if (bus.mem_resp) begin
                if (bus.trigger) begin
                    m_start(bus.trigger_addr);
                end else begin
                    wa = m_reqs.pop_front();
                    m_buf[wa] = bus.mem_rdata;
                end
            end else if (bus.trigger) begin
                m_abort     = 1'b1;
                m_cur       = m_reqs[0];
                m_reqs.delete();
                m_pend      = 1'b1;
                m_pend_addr = bus.trigger_addr;
            end
        end else begin
            if (bus.flush) begin
                m_buf.delete();
                m_pend = 1'b0;
            end else if (bus.trigger) begin
                m_pend      = 1'b1;
                m_pend_addr = bus.trigger_addr;
            end
            if (bus.mem_resp) begin
                m_abort = 1'b0;
                if (m_pend) begin
                    m_pend = 1'b0;
                    m_start(m_pend_addr);
                end
            end
        end
    endtask

    // model update at each active edge, cleared asynchronously by reset
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_buf.delete();
            m_reqs.delete();
            m_abort = 1'b0;
            m_pend  = 1'b0;
        end else begin
            m_step();
        end
    end

    // compare DUT against the model mid-cycle
    initial forever begin
        logic [AW-1:0] la;
        bit exp_read;
        bit exp_hit;
        @(negedge clk);
        exp_read = m_abort || (m_reqs.size() != 0);
        chk("cyc busy", bus.busy, exp_read);
        chk("cyc mem_read", bus.mem_read, exp_read);
        if (exp_read) chk("cyc mem_address", bus.mem_address, m_abort ? m_cur : m_reqs[0]);
        la = line(bus.lookup_addr);
        exp_hit = m_buf.exists(la);
        chk("cyc lookup_hit", bus.lookup_hit, exp_hit);
        chk("cyc lookup_data", bus.lookup_data, exp_hit ? m_buf[la] : '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_trigger(input logic [AW-1:0] a);
        bus.trigger      = 1'b1;
        bus.trigger_addr = a;
        tick();
        bus.trigger      = 1'b0;
    endtask

    task automatic serve(input int wait_cyc);
        int guard = 0;
        while (bus.mem_read !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (bus.mem_read !== 1'b1) begin
            chk("serve wait mem_read", bus.mem_read, 1'b1);
            return;
        end
        req_log.push_back(bus.mem_address);
        repeat (wait_cyc - 1) tick();
        bus.mem_rdata = dat(bus.mem_address);
        bus.mem_resp  = 1'b1;
        tick();
        bus.mem_resp  = 1'b0;
    endtask

    task automatic probe(input string name, input logic [AW-1:0] a, input logic h, input logic [LBITS-1:0] d);
        bus.lookup_addr = a;
        #1;
        chk({name, " hit"}, bus.lookup_hit, h);
        chk({name, " data"}, bus.lookup_data, d);
        tick();
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.trigger        = 1'b0;
        bus.trigger_addr   = '0;
        bus.flush          = 1'b0;
        bus.lookup_addr    = '0;
        bus.lookup_consume = 1'b0;
        bus.mem_rdata      = '0;
        bus.mem_resp       = 1'b0;

        // reset state
        repeat (3) tick();
        chk("rst busy", bus.busy, 1'b0);
        chk("rst mem_read", bus.mem_read, 1'b0);
        chk("rst mem_address", bus.mem_address, 32'h0);
        chk("rst hit", bus.lookup_hit, 1'b0);
        rst = 1'b1;
        tick();

        // basic four-line stream
        pulse_trigger(32'h1004);
        chk("t1 mem_read rise", bus.mem_read, 1'b1);
        chk("t1 first addr", bus.mem_address, 32'h1020);
        req_log.delete();
        repeat (4) serve(3);
        chk("t1 busy done", bus.busy, 1'b0);
        chk("t1 n reqs", req_log.size(), 4);
        if (req_log.size() == 4) begin
            chk("t1 req0", req_log[0], 32'h1020);
            chk("t1 req1", req_log[1], 32'h1040);
            chk("t1 req2", req_log[2], 32'h1060);
            chk("t1 req3", req_log[3], 32'h1080);
        end
        probe("t1 1047", 32'h1047, 1'b1, dat(32'h1040));
        probe("t1 10A0", 32'h10A0, 1'b0, '0);
        probe("t1 1004", 32'h1004, 1'b0, '0);

        // consume one entry
        bus.lookup_addr    = 32'h1040;
        bus.lookup_consume = 1'b1;
        #1;
        chk("cons hit now", bus.lookup_hit, 1'b1);
        tick();
        bus.lookup_consume = 1'b0;
        #1;
        chk("cons miss after", bus.lookup_hit, 1'b0);
        tick();
        probe("cons 1020", 32'h1020, 1'b1, dat(32'h1020));
        probe("cons 1060", 32'h1060, 1'b1, dat(32'h1060));
        probe("cons 1080", 32'h1080, 1'b1, dat(32'h1080));

        // page stop
        req_log.delete();
        pulse_trigger(32'h1FA0);
        repeat (2) serve(3);
        tick();
        chk("pg busy", bus.busy, 1'b0);
        chk("pg n reqs", req_log.size(), 2);
        if (req_log.size() == 2) begin
            chk("pg req0", req_log[0], 32'h1FC0);
            chk("pg req1", req_log[1], 32'h1FE0);
        end
        probe("pg 1FE0", 32'h1FE0, 1'b1, dat(32'h1FE0));
        probe("pg 1020 gone", 32'h1020, 1'b0, '0);
        pulse_trigger(32'hFFFF_FFE0);
        chk("wrap busy", bus.busy, 1'b0);
        chk("wrap mem_read", bus.mem_read, 1'b0);
        tick();
        chk("wrap busy later", bus.busy, 1'b0);
        probe("wrap 1FE0 gone", 32'h1FE0, 1'b0, '0);

        // retrigger while a read is outstanding
        pulse_trigger(32'h2000);
        chk("rt first addr", bus.mem_address, 32'h2020);
        tick();
        pulse_trigger(32'h8000);
        chk("rt abort read", bus.mem_read, 1'b1);
        chk("rt abort addr", bus.mem_address, 32'h2020);
        serve(2);
        chk("rt restart addr", bus.mem_address, 32'h8020);
        probe("rt 2020", 32'h2020, 1'b0, '0);
        repeat (4) serve(3);
        probe("rt 8060", 32'h8060, 1'b1, dat(32'h8060));

        // trigger and response in the same cycle
        pulse_trigger(32'h3000);
        tick();
        bus.trigger      = 1'b1;
        bus.trigger_addr = 32'h5000;
        bus.mem_rdata    = dat(32'h3020);
        bus.mem_resp     = 1'b1;
        tick();
        bus.trigger  = 1'b0;
        bus.mem_resp = 1'b0;
        chk("sc addr", bus.mem_address, 32'h5020);
        chk("sc read", bus.mem_read, 1'b1);
        probe("sc 3020", 32'h3020, 1'b0, '0);
        repeat (4) serve(3);
        probe("sc 5080", 32'h5080, 1'b1, dat(32'h5080));

        // flush beats a simultaneous trigger in IDLE
        bus.flush        = 1'b1;
        bus.trigger      = 1'b1;
        bus.trigger_addr = 32'h9000;
        tick();
        bus.flush   = 1'b0;
        bus.trigger = 1'b0;
        chk("ft busy", bus.busy, 1'b0);
        probe("ft 5020", 32'h5020, 1'b0, '0);

        // flush mid-stream
        pulse_trigger(32'h6000);
        serve(3);
        probe("fl 6020 before", 32'h6020, 1'b1, dat(32'h6020));
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("fl busy abort", bus.busy, 1'b1);
        chk("fl addr abort", bus.mem_address, 32'h6040);
        probe("fl 6020 after", 32'h6020, 1'b0, '0);
        serve(2);
        chk("fl busy end", bus.busy, 1'b0);
        chk("fl read end", bus.mem_read, 1'b0);
        probe("fl 6040", 32'h6040, 1'b0, '0);

        // asynchronous reset mid-fetch
        pulse_trigger(32'h7000);
        serve(3);
        bus.lookup_addr = 32'h7020;
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("ar mem_read", bus.mem_read, 1'b0);
        chk("ar busy", bus.busy, 1'b0);
        chk("ar mem_address", bus.mem_address, 32'h0);
        chk("ar hit", bus.lookup_hit, 1'b0);
        bus.mem_rdata = dat(32'h7040);
        bus.mem_resp  = 1'b1;
        tick();
        bus.mem_resp = 1'b0;
        rst = 1'b1;
        tick();
        bus.mem_resp = 1'b1;
        tick();
        bus.mem_resp = 1'b0;
        chk("ar busy after resp", bus.busy, 1'b0);
        probe("ar 7020", 32'h7020, 1'b0, '0);
        probe("ar 7040", 32'h7040, 1'b0, '0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
